// File: rtl/flop_bank_arbiter_pkg.sv
// Shared definitions for the register-bank write arbiter: FSM encoding,
// default widths shared with the register bank, and a constant clog2 helper.
package flop_bank_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam int N_REQ_DEF     = 4;
  localparam int DATA_W_DEF    = 8;
  localparam int ADDR_W_DEF    = 3;
  localparam int WR_CYCLES_DEF = 2;

  // Bits needed to index `value` items; never less than 1 so ports stay legal.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) result = result + 1;
    return result;
  endfunction

endpackage

// File: rtl/flop_bank_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first active request at or above ptr,
// wrapping modulo N_REQ.
module rr_priority_picker
  import flop_bank_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDX_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] winner_oh,
  output logic [IDX_W-1:0] winner_idx,
  output logic             valid
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the loop
    // leaves one unassigned, which would otherwise infer a latch.
    winner_oh  = '0;
    winner_idx = '0;
    valid      = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!valid && req[(int'(ptr) + k) % N_REQ]) begin
        valid                               = 1'b1;
        winner_oh[(int'(ptr) + k) % N_REQ]  = 1'b1;
        winner_idx                          = IDX_W'((int'(ptr) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/flop_bank_arbiter.sv
// Round-robin write sequencer for the shared flop bank: grants one requester,
// holds address/data for WR_CYCLES, pulses bank_we in the last cycle, then acks.
module flop_bank_arbiter
  import flop_bank_arbiter_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int WR_CYCLES = WR_CYCLES_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          ack,
  output logic                      bank_we,
  output logic [ADDR_W-1:0]         bank_addr,
  output logic [DATA_W-1:0]         bank_d,
  output logic                      busy,
  output logic [clog2(N_REQ)-1:0]   grant_id
);

  localparam int IDX_W = clog2(N_REQ);
  localparam int CNT_W = clog2(WR_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WR_CYCLES - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   ptr;
  logic [N_REQ-1:0]   pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;

  rr_priority_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req        (req),
    .ptr        (ptr),
    .winner_oh  (pick_oh),
    .winner_idx (pick_idx),
    .valid      (pick_valid)
  );

  // NOTE: all state below uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= '0;
      ack       <= '0;
      bank_we   <= 1'b0;
      bank_addr <= '0;
      bank_d    <= '0;
      busy      <= 1'b0;
      grant_id  <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          if (pick_valid) begin
            state     <= WRITE;
            cnt       <= CNT_LOAD;
            grant_id  <= pick_idx;
            bank_addr <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
            bank_d    <= req_data[int'(pick_idx)*DATA_W +: DATA_W];
            // A one-cycle window enables the bank in its first (and only) cycle.
            bank_we   <= (WR_CYCLES == 1);
            busy      <= 1'b1;
          end
        end
        WRITE: begin
          if (cnt == '0) begin
            state   <= ACK;
            bank_we <= 1'b0;
            ack     <= N_REQ'(1) << grant_id;
          end else begin
            cnt     <= cnt - 1'b1;
            bank_we <= (cnt == CNT_W'(1));
          end
        end
        ACK: begin
          state <= IDLE;
          ack   <= '0;
          busy  <= 1'b0;
          ptr   <= (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;
        end
        default: begin
          state   <= IDLE;
          ack     <= '0;
          bank_we <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // The one-hot winner is kept for visibility; the index drives all muxing.
  logic unused_pick_oh;
  assign unused_pick_oh = ^pick_oh;

endmodule

// File: tb/tb_flop_bank_arbiter.sv
// Self-checking bench for flop_bank_arbiter: directed scenarios plus random
// traffic, all compared every cycle against a transaction-timeline model.
module tb_flop_bank_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int WR = 2;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    ack;
  logic            bank_we;
  logic [AW-1:0]   bank_addr;
  logic [DW-1:0]   bank_d;
  logic            busy;
  logic [IW-1:0]   grant_id;

  flop_bank_arbiter #(
    .N_REQ     (N),
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .WR_CYCLES (WR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .ack       (ack),
    .bank_we   (bank_we),
    .bank_addr (bank_addr),
    .bank_d    (bank_d),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference: one record for the latest granted transaction, expressed as
  // absolute cycle numbers of its write-enable, ack and return to idle.
  int            m_ptr = 0;
  int            m_gid = 0;
  int            m_grant = -10;
  int            m_free = 0;
  int            t_we = -10;
  int            t_ack = -10;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_ptr = 0; m_gid = 0; m_addr = '0; m_data = '0;
      m_grant = -10; m_free = 0; t_we = -10; t_ack = -10;
    end else if (cyc >= m_free && req != '0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (req[j]) begin
          m_gid   = j;
          m_addr  = req_addr[j*AW +: AW];
          m_data  = req_data[j*DW +: DW];
          m_grant = cyc;
          t_we    = cyc + WR;
          t_ack   = cyc + WR + 1;
          m_free  = cyc + WR + 2;
          m_ptr   = (j + 1) % N;
          break;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("busy", busy, (cyc > m_grant && cyc < m_free));
    check("bank_we", bank_we, (cyc == t_we));
    check("ack", ack, (cyc == t_ack) ? (32'd1 << m_gid) : 32'd0);
    check("bank_addr", bank_addr, m_addr);
    check("bank_d", bank_d, m_data);
    check("grant_id", grant_id, m_gid);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic set_req(input int i, input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = r;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic drain();
    req = '0;
    for (int i = 0; i < WR + 3; i++) step();
  endtask

  initial begin
    int expect_id;
    int last_ack;
    int n_acks;

    // Reset held two cycles with every requester active.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 2), DW'(8'h50 + i));
    rst = 1'b1;
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    rst = 1'b0;
    step();
    check("post_rst_ack", ack, 0);
    check("post_rst_grant", grant_id, 0);
    drain();

    // Single write from requester 2.
    do_reset();
    set_req(2, 1'b1, 3'd5, 8'hA5);
    step();
    check("single_we_early", bank_we, 0);
    step();
    check("single_we", bank_we, 1);
    check("single_addr", bank_addr, 5);
    check("single_d", bank_d, 8'hA5);
    req[2] = 1'b0;
    step();
    check("single_ack", ack, 4'b0100);
    check("single_we_off", bank_we, 0);
    step();
    check("single_idle", busy, 0);
    drain();

    // All four requesting: served 0,1,2,3, each dropping after its ack.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 1), DW'(8'h10 + i));
    expect_id = 0;
    last_ack = -1;
    for (int n = 0; n < 4 * (WR + 2); n++) begin
      step();
      if (cyc == t_we) check("simul_data", bank_d, 8'h10 + expect_id);
      if (cyc == t_ack) begin
        check("simul_order", grant_id, expect_id);
        if (last_ack >= 0) check("simul_gap", cyc - last_ack, WR + 2);
        last_ack = cyc;
        req[m_gid] = 1'b0;
        expect_id++;
      end
    end
    check("simul_count", expect_id, 4);
    drain();

    // Fairness between requesters 0 and 3 held continuously.
    do_reset();
    set_req(0, 1'b1, 3'd1, 8'h0F);
    set_req(3, 1'b1, 3'd7, 8'hF0);
    n_acks = 0;
    for (int n = 0; n < 8 * (WR + 2); n++) begin
      step();
      if (cyc == t_ack) begin
        check("fair_order", grant_id, (n_acks % 2 == 0) ? 0 : 3);
        n_acks++;
      end
    end
    check("fair_count", n_acks, 8);
    drain();

    // Reset during the first WRITE cycle of requester 1.
    do_reset();
    set_req(1, 1'b1, 3'd2, 8'h77);
    step();
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    step();
    check("abort_we", bank_we, 0);
    check("abort_ack", ack, 0);
    rst = 1'b0;
    set_req(0, 1'b1, 3'd3, 8'h33);
    step();
    check("abort_winner", grant_id, 0);
    drain();

    // Requester 3 withdraws and changes data right after its grant.
    do_reset();
    set_req(3, 1'b1, 3'd6, 8'h3C);
    step();
    set_req(3, 1'b0, 3'd1, 8'hFF);
    for (int n = 0; n < WR + 2; n++) begin
      step();
      if (cyc == t_we) check("drop_data", bank_d, 8'h3C);
      if (cyc == t_ack) check("drop_ack", ack, 4'b1000);
    end
    drain();

    // Random traffic with occasional resets.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      req      = N'($urandom_range(0, (1 << N) - 1));
      req_addr = (N*AW)'($urandom);
      req_data = (N*DW)'($urandom);
      rst      = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
